// File: rtl/lb_dp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lb_dp_buffer
// Description : Dual-port local buffer for CNN layer data. Both ports can
//               read or write every cycle. Reads are fully pipelined with a
//               latency of RD_LAT cycles and a per-read valid pulse.
//               A same-address write on one port is forwarded to a read on
//               the other port in the same cycle. When both ports write the
//               same address, port A wins and the event is counted.
//               With PINGPONG=1 there are two banks: port A uses bank
//               bank_sel and port B uses the other bank.
// Ports       : CK, RSTN             - clock, async active-low reset
//               a_* / b_*            - en, we, addr, wdata in; rdata, rvalid out
//               bank_swap / bank_sel - ping-pong bank control / current A bank
//               wcoll_cnt            - saturating write-write collision count
//               addr_err             - sticky out-of-range access flag
// Revision    : 1.0 - initial release
// ============================================================================
module lb_dp_buffer #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 144,
    parameter int AW       = $clog2(DEPTH),
    parameter int PINGPONG = 0,
    parameter int RD_LAT   = 1
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             a_en,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic [WIDTH-1:0] a_rdata,
    output logic             a_rvalid,
    input  logic             b_en,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic [WIDTH-1:0] b_rdata,
    output logic             b_rvalid,
    input  logic             bank_swap,
    output logic             bank_sel,
    output logic [15:0]      wcoll_cnt,
    output logic             addr_err
);

    localparam int c_NBANK = (PINGPONG != 0) ? 2 : 1;
    localparam int c_MW    = $clog2(c_NBANK * DEPTH);

    logic [WIDTH-1:0] r_mem [c_NBANK*DEPTH];

    logic             r_bank_sel;
    logic [15:0]      r_wcoll_cnt;
    logic             r_addr_err;
    logic [WIDTH-1:0] r_a_rdata, r_b_rdata;
    logic             r_a_rvalid, r_b_rvalid;

    logic             w_a_bank, w_b_bank;
    logic [c_MW-1:0]  w_a_idx, w_b_idx;
    logic             w_a_inr, w_b_inr;
    logic             w_a_wr, w_b_wr, w_a_rd, w_b_rd;
    logic             w_same, w_coll;
    logic             w_a_wr_ok, w_b_wr_ok;
    logic [WIDTH-1:0] w_a_rd_data, w_b_rd_data;
    logic             w_a_pv, w_b_pv;
    logic [WIDTH-1:0] w_a_pd, w_b_pd;

    // Bank mapping: the bank_sel register value before the edge applies, so
    // accesses in a bank_swap cycle still use the old mapping.
    assign w_a_bank = (PINGPONG != 0) ? r_bank_sel  : 1'b0;
    assign w_b_bank = (PINGPONG != 0) ? ~r_bank_sel : 1'b0;

    assign w_a_idx = c_MW'(a_addr) + (w_a_bank ? c_MW'(DEPTH) : '0);
    assign w_b_idx = c_MW'(b_addr) + (w_b_bank ? c_MW'(DEPTH) : '0);

    assign w_a_inr = (32'(a_addr) < 32'(DEPTH));
    assign w_b_inr = (32'(b_addr) < 32'(DEPTH));

    assign w_a_wr = a_en &  a_we;
    assign w_a_rd = a_en & ~a_we;
    assign w_b_wr = b_en &  b_we;
    assign w_b_rd = b_en & ~b_we;

    // Ports only share storage in single-bank mode.
    assign w_same = (PINGPONG == 0) && (a_addr == b_addr);
    assign w_coll = w_a_wr & w_b_wr & w_same;

    assign w_a_wr_ok = w_a_wr & w_a_inr;
    assign w_b_wr_ok = w_b_wr & w_b_inr & ~w_coll;

    // Read path: out-of-range reads return zero; a same-cycle write from the
    // opposite port to the same word is forwarded (write-first).
    always_comb begin
        w_a_rd_data = '0;
        if (w_a_inr) begin
            w_a_rd_data = (w_b_wr && w_same) ? b_wdata : r_mem[w_a_idx];
        end
    end

    always_comb begin
        w_b_rd_data = '0;
        if (w_b_inr) begin
            w_b_rd_data = (w_a_wr && w_same) ? a_wdata : r_mem[w_b_idx];
        end
    end

    // Storage is not reset. Port B's write is suppressed on a collision so
    // port A's data lands.
    always_ff @(posedge CK) begin
        if (w_a_wr_ok) begin
            r_mem[w_a_idx] <= a_wdata;
        end
        if (w_b_wr_ok) begin
            r_mem[w_b_idx] <= b_wdata;
        end
    end

    // Optional extra read stage for RD_LAT=2.
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             r_a_v1, r_b_v1;
            logic [WIDTH-1:0] r_a_d1, r_b_d1;

            always_ff @(posedge CK or negedge RSTN) begin
                if (!RSTN) begin
                    r_a_v1 <= 1'b0;
                    r_b_v1 <= 1'b0;
                    r_a_d1 <= '0;
                    r_b_d1 <= '0;
                end else begin
                    r_a_v1 <= w_a_rd;
                    r_b_v1 <= w_b_rd;
                    if (w_a_rd) begin
                        r_a_d1 <= w_a_rd_data;
                    end
                    if (w_b_rd) begin
                        r_b_d1 <= w_b_rd_data;
                    end
                end
            end

            assign w_a_pv = r_a_v1;
            assign w_a_pd = r_a_d1;
            assign w_b_pv = r_b_v1;
            assign w_b_pd = r_b_d1;
        end else begin : g_lat1
            assign w_a_pv = w_a_rd;
            assign w_a_pd = w_a_rd_data;
            assign w_b_pv = w_b_rd;
            assign w_b_pd = w_b_rd_data;
        end
    endgenerate

    // Output registers: rdata only loads on a valid read so it holds
    // between reads.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= w_a_pv;
            r_b_rvalid <= w_b_pv;
            if (w_a_pv) begin
                r_a_rdata <= w_a_pd;
            end
            if (w_b_pv) begin
                r_b_rdata <= w_b_pd;
            end
        end
    end

    // Status registers.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_bank_sel  <= 1'b0;
            r_wcoll_cnt <= 16'h0000;
            r_addr_err  <= 1'b0;
        end else begin
            if ((PINGPONG != 0) && bank_swap) begin
                r_bank_sel <= ~r_bank_sel;
            end
            if (w_coll && (r_wcoll_cnt != 16'hFFFF)) begin
                r_wcoll_cnt <= r_wcoll_cnt + 16'h0001;
            end
            if ((a_en && !w_a_inr) || (b_en && !w_b_inr)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign a_rdata   = r_a_rdata;
    assign a_rvalid  = r_a_rvalid;
    assign b_rdata   = r_b_rdata;
    assign b_rvalid  = r_b_rvalid;
    assign bank_sel  = r_bank_sel;
    assign wcoll_cnt = r_wcoll_cnt;
    assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_lb_dp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lb_dp_buffer
// Description : Self-checking bench for lb_dp_buffer. Three instances share
//               one set of inputs: [0] single bank RD_LAT=1, [1] ping-pong
//               RD_LAT=1, [2] single bank RD_LAT=2. A behavioural model of
//               each configuration predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lb_dp_buffer;

    localparam int W  = 128;
    localparam int D  = 144;
    localparam int AW = 8;

    logic          CK = 1'b0;
    logic          RSTN = 1'b1;
    logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [W-1:0]  a_wdata = '0, b_wdata = '0;
    logic          bank_swap = 1'b0;

    logic [W-1:0]  a_rdata_o [3];
    logic [W-1:0]  b_rdata_o [3];
    logic          a_rvalid_o [3];
    logic          b_rvalid_o [3];
    logic          bank_sel_o [3];
    logic          addr_err_o [3];
    logic [15:0]   wcoll_o [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            lb_dp_buffer #(
                .WIDTH(W), .DEPTH(D), .AW(AW),
                .PINGPONG((g == 1) ? 1 : 0),
                .RD_LAT((g == 2) ? 2 : 1)
            ) u_dut (
                .CK(CK), .RSTN(RSTN),
                .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
                .a_rdata(a_rdata_o[g]), .a_rvalid(a_rvalid_o[g]),
                .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
                .b_rdata(b_rdata_o[g]), .b_rvalid(b_rvalid_o[g]),
                .bank_swap(bank_swap), .bank_sel(bank_sel_o[g]),
                .wcoll_cnt(wcoll_o[g]), .addr_err(addr_err_o[g])
            );
        end
    endgenerate

    always #5 CK = ~CK;

    int checks = 0;
    int errors = 0;

    // Reference model state per configuration.
    logic [W-1:0] m_mem [3][2][D];
    logic         m_bsel [3];
    logic [15:0]  m_cnt [3];
    logic         m_err [3];
    logic         e_av [3], e_bv [3], p_av [3], p_bv [3];
    logic [W-1:0] e_ad [3], e_bd [3], p_ad [3], p_bd [3];

    function automatic bit is_pp(int c);
        return (c == 1);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_bsel[c] = 1'b0; m_cnt[c] = 16'h0; m_err[c] = 1'b0;
            e_av[c] = 1'b0; e_bv[c] = 1'b0; p_av[c] = 1'b0; p_bv[c] = 1'b0;
            e_ad[c] = '0; e_bd[c] = '0; p_ad[c] = '0; p_bd[c] = '0;
        end
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0; bank_swap = 1'b0;
    endtask

    // Advance one clock edge and apply the buffer rules to the model using
    // the inputs that were present at that edge.
    task automatic step();
        int ba, bb;
        logic rav, rbv, collide;
        logic [W-1:0] ra, rb;
        @(posedge CK);
        #1;
        if (!RSTN) return;
        for (int c = 0; c < 3; c++) begin
            ba = is_pp(c) ? int'(m_bsel[c]) : 0;
            bb = is_pp(c) ? int'(!m_bsel[c]) : 0;
            rav = a_en && !a_we;
            rbv = b_en && !b_we;
            collide = !is_pp(c) && a_en && a_we && b_en && b_we && (a_addr == b_addr);
            ra = '0;
            rb = '0;
            if (rav && a_addr < D)
                ra = (!is_pp(c) && b_en && b_we && b_addr == a_addr) ? b_wdata : m_mem[c][ba][a_addr];
            if (rbv && b_addr < D)
                rb = (!is_pp(c) && a_en && a_we && a_addr == b_addr) ? a_wdata : m_mem[c][bb][b_addr];
            if (a_en && a_we && a_addr < D) m_mem[c][ba][a_addr] = a_wdata;
            if (b_en && b_we && b_addr < D && !collide) m_mem[c][bb][b_addr] = b_wdata;
            if ((a_en && a_addr >= D) || (b_en && b_addr >= D)) m_err[c] = 1'b1;
            if (collide && m_cnt[c] != 16'hFFFF) m_cnt[c] = m_cnt[c] + 16'h1;
            if (is_pp(c) && bank_swap) m_bsel[c] = !m_bsel[c];
            if (c != 2) begin
                e_av[c] = rav; if (rav) e_ad[c] = ra;
                e_bv[c] = rbv; if (rbv) e_bd[c] = rb;
            end else begin
                e_av[c] = p_av[c]; if (p_av[c]) e_ad[c] = p_ad[c];
                e_bv[c] = p_bv[c]; if (p_bv[c]) e_bd[c] = p_bd[c];
                p_av[c] = rav; p_ad[c] = ra;
                p_bv[c] = rbv; p_bd[c] = rb;
            end
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b1;
        #2;
        RSTN = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (a_rdata_o[c] !== '0 || b_rdata_o[c] !== '0 || a_rvalid_o[c] !== 1'b0 ||
                b_rvalid_o[c] !== 1'b0 || bank_sel_o[c] !== 1'b0 || wcoll_o[c] !== 16'h0 ||
                addr_err_o[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got av=%b bv=%b sel=%b cnt=%h err=%b ad=%h bd=%h, exp all zero",
                         c, a_rvalid_o[c], b_rvalid_o[c], bank_sel_o[c], wcoll_o[c], addr_err_o[c],
                         a_rdata_o[c], b_rdata_o[c]);
            end
        end
        step();
        step();
        @(negedge CK);
        RSTN = 1'b1;
    endtask

    // Fill every word of every bank with random data (distinct addresses on
    // the two ports, so no collisions).
    task automatic init_mem();
        for (int i = 0; i < D; i++) begin
            a_en = 1'b1; a_we = 1'b1; a_addr = AW'(i); a_wdata = {$urandom, $urandom, $urandom, $urandom};
            b_en = 1'b1; b_we = 1'b1; b_addr = AW'((i + 72) % D); b_wdata = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        idle();
        step();
    endtask

    task automatic test_write_read();
        logic [W-1:0] v;
        v = {16{8'hA5}};
        a_en = 1'b1; a_we = 1'b1; a_addr = 8'd5; a_wdata = v;
        step();
        idle();
        b_en = 1'b1; b_we = 1'b0; b_addr = 8'd5;
        step();
        idle();
        checks++;
        if (b_rvalid_o[0] !== 1'b1 || b_rdata_o[0] !== v || a_rvalid_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd: got bv=%b bd=%h av=%b, exp bv=1 bd=%h av=0",
                     b_rvalid_o[0], b_rdata_o[0], a_rvalid_o[0], v);
        end
        step();
        checks++;
        if (b_rvalid_o[0] !== 1'b0 || b_rdata_o[0] !== v) begin
            errors++;
            $display("FAIL wr_rd_hold: got bv=%b bd=%h, exp bv=0 bd=%h", b_rvalid_o[0], b_rdata_o[0], v);
        end
    endtask

    task automatic test_forward();
        a_en = 1'b1; a_we = 1'b1; a_addr = 8'd10; a_wdata = W'(16'h1234);
        b_en = 1'b1; b_we = 1'b0; b_addr = 8'd10;
        step();
        idle();
        checks++;
        if (b_rvalid_o[0] !== 1'b1 || b_rdata_o[0] !== W'(16'h1234)) begin
            errors++;
            $display("FAIL fwd_a2b: got bv=%b bd=%h, exp bv=1 bd=1234", b_rvalid_o[0], b_rdata_o[0]);
        end
        a_en = 1'b1; a_we = 1'b0; a_addr = 8'd10;
        b_en = 1'b1; b_we = 1'b1; b_addr = 8'd10; b_wdata = W'(16'h5678);
        step();
        idle();
        checks++;
        if (a_rvalid_o[0] !== 1'b1 || a_rdata_o[0] !== W'(16'h5678)) begin
            errors++;
            $display("FAIL fwd_b2a: got av=%b ad=%h, exp av=1 ad=5678", a_rvalid_o[0], a_rdata_o[0]);
        end
        a_en = 1'b1; a_we = 1'b0; a_addr = 8'd10;
        step();
        idle();
        checks++;
        if (a_rdata_o[0] !== W'(16'h5678)) begin
            errors++;
            $display("FAIL fwd_readback: got %h exp 5678", a_rdata_o[0]);
        end
    endtask

    task automatic test_wcoll();
        a_en = 1'b1; a_we = 1'b1; a_addr = 8'd3; a_wdata = W'(8'h11);
        b_en = 1'b1; b_we = 1'b1; b_addr = 8'd3; b_wdata = W'(8'h22);
        step();
        idle();
        a_en = 1'b1; a_addr = 8'd3;
        step();
        idle();
        checks++;
        if (a_rdata_o[0] !== W'(8'h11) || wcoll_o[0] !== 16'd1 || wcoll_o[1] !== 16'd0) begin
            errors++;
            $display("FAIL wcoll_one: got ad=%h cnt=%h pp_cnt=%h, exp ad=11 cnt=1 pp_cnt=0",
                     a_rdata_o[0], wcoll_o[0], wcoll_o[1]);
        end
        a_en = 1'b1; a_we = 1'b1; a_addr = 8'd3; a_wdata = W'(8'h11);
        b_en = 1'b1; b_we = 1'b1; b_addr = 8'd3; b_wdata = W'(8'h22);
        for (int i = 0; i < 65534; i++) step();
        checks++;
        if (wcoll_o[0] !== 16'hFFFF || wcoll_o[2] !== 16'hFFFF) begin
            errors++;
            $display("FAIL wcoll_sat: got %h/%h exp ffff", wcoll_o[0], wcoll_o[2]);
        end
        step();
        step();
        idle();
        checks++;
        if (wcoll_o[0] !== 16'hFFFF || wcoll_o[0] !== m_cnt[0]) begin
            errors++;
            $display("FAIL wcoll_hold: got %h exp ffff", wcoll_o[0]);
        end
    endtask

    task automatic test_pingpong();
        a_en = 1'b1; a_we = 1'b1; a_addr = 8'd0; a_wdata = W'(8'hAA);
        step();
        idle();
        bank_swap = 1'b1;
        step();
        idle();
        checks++;
        if (bank_sel_o[1] !== 1'b1 || bank_sel_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL pp_sel: got pp=%b sb=%b exp pp=1 sb=0", bank_sel_o[1], bank_sel_o[0]);
        end
        a_en = 1'b1; a_we = 1'b1; a_addr = 8'd0; a_wdata = W'(8'hBB);
        b_en = 1'b1; b_we = 1'b0; b_addr = 8'd0;
        step();
        idle();
        checks++;
        if (b_rvalid_o[1] !== 1'b1 || b_rdata_o[1] !== W'(8'hAA)) begin
            errors++;
            $display("FAIL pp_read: got bv=%b bd=%h exp bv=1 bd=aa", b_rvalid_o[1], b_rdata_o[1]);
        end
        a_en = 1'b1; a_we = 1'b0; a_addr = 8'd0;
        step();
        idle();
        checks++;
        if (a_rdata_o[1] !== W'(8'hBB) || wcoll_o[1] !== 16'd0) begin
            errors++;
            $display("FAIL pp_abank: got ad=%h cnt=%h exp ad=bb cnt=0", a_rdata_o[1], wcoll_o[1]);
        end
    endtask

    task automatic test_lat2();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                b_en = 1'b1; b_we = 1'b0; b_addr = AW'(i);
            end else begin
                idle();
            end
            step();
            checks++;
            if (b_rvalid_o[2] !== ((i >= 1) && (i <= 3)) || b_rdata_o[2] !== e_bd[2] ||
                (i >= 1 && i <= 3 && b_rdata_o[2] !== m_mem[2][0][i-1])) begin
                errors++;
                $display("FAIL lat2_seq%0d: got bv=%b bd=%h exp bv=%b bd=%h", i, b_rvalid_o[2],
                         b_rdata_o[2], ((i >= 1) && (i <= 3)), e_bd[2]);
            end
        end
        b_en = 1'b1; b_we = 1'b0; b_addr = 8'd7;
        step();
        b_addr = 8'd8;
        step();
        idle();
        RSTN = 1'b0;
        #1;
        model_reset();
        checks++;
        if (b_rvalid_o[2] !== 1'b0 || b_rdata_o[2] !== '0 || wcoll_o[0] !== 16'd0) begin
            errors++;
            $display("FAIL lat2_rst: got bv=%b bd=%h cnt=%h exp 0", b_rvalid_o[2], b_rdata_o[2], wcoll_o[0]);
        end
        step();
        @(negedge CK);
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b_rvalid_o[2] !== 1'b0 || b_rvalid_o[0] !== 1'b0 || a_rvalid_o[2] !== 1'b0) begin
                errors++;
                $display("FAIL lat2_flush%0d: got bv=%b exp 0", i, b_rvalid_o[2]);
            end
        end
    endtask

    task automatic test_addr_err();
        a_en = 1'b1; a_we = 1'b0; a_addr = 8'd144;
        step();
        idle();
        checks++;
        if (a_rvalid_o[0] !== 1'b1 || a_rdata_o[0] !== '0 || addr_err_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: got av=%b ad=%h err=%b exp av=1 ad=0 err=1",
                     a_rvalid_o[0], a_rdata_o[0], addr_err_o[0]);
        end
        b_en = 1'b1; b_we = 1'b1; b_addr = 8'd200; b_wdata = {4{32'hDEADBEEF}};
        step();
        idle();
        step();
        a_en = 1'b1; a_addr = 8'd56;
        b_en = 1'b1; b_addr = 8'd72;
        step();
        idle();
        checks++;
        if (a_rdata_o[0] !== m_mem[0][0][56] || b_rdata_o[0] !== m_mem[0][0][72] || addr_err_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL oor_write: got ad=%h bd=%h err=%b exp ad=%h bd=%h err=1",
                     a_rdata_o[0], b_rdata_o[0], addr_err_o[0], m_mem[0][0][56], m_mem[0][0][72]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            a_en = 1'($urandom); a_we = 1'($urandom);
            b_en = 1'($urandom); b_we = 1'($urandom);
            a_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 159)) : 8'($urandom_range(0, 5));
            b_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 159)) : 8'($urandom_range(0, 5));
            a_wdata = {$urandom, $urandom, $urandom, $urandom};
            b_wdata = {$urandom, $urandom, $urandom, $urandom};
            bank_swap = ($urandom_range(0, 7) == 0);
            step();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (a_rvalid_o[c] !== e_av[c] || a_rdata_o[c] !== e_ad[c] ||
                    b_rvalid_o[c] !== e_bv[c] || b_rdata_o[c] !== e_bd[c]) begin
                    errors++;
                    $display("FAIL rand_data dut%0d cyc%0d: got av=%b ad=%h bv=%b bd=%h exp av=%b ad=%h bv=%b bd=%h",
                             c, n, a_rvalid_o[c], a_rdata_o[c], b_rvalid_o[c], b_rdata_o[c],
                             e_av[c], e_ad[c], e_bv[c], e_bd[c]);
                end
                checks++;
                if (bank_sel_o[c] !== m_bsel[c] || wcoll_o[c] !== m_cnt[c] || addr_err_o[c] !== m_err[c]) begin
                    errors++;
                    $display("FAIL rand_status dut%0d cyc%0d: got sel=%b cnt=%h err=%b exp sel=%b cnt=%h err=%b",
                             c, n, bank_sel_o[c], wcoll_o[c], addr_err_o[c], m_bsel[c], m_cnt[c], m_err[c]);
                end
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        init_mem();
        test_write_read();
        test_forward();
        test_wcoll();
        test_pingpong();
        test_lat2();
        test_addr_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lb_dp_buffer.md
Name: lb_dp_buffer

Overview:
Parametrised dual-port local buffer for CNN layer data, sized per layer by parameters. Replaces the per-layer fixed SRAM shells. Adds:
- deterministic same-address collision resolution with write-to-read forwarding
- a registered read pipeline with valid flags
- an optional ping-pong bank mode, so one layer's writer and the next layer's reader use separate banks.

Parameters:
WIDTH, 128, data word width in bits.
DEPTH, 144, words per bank.
AW, $clog2(DEPTH), address width.
PINGPONG, 0, 0 = single shared bank; 1 = two banks, port A on write bank, port B on the other.
RD_LAT, 1, read latency in cycles (1 or 2).

Ports:
CK  in  1  clock, rising edge.
RSTN  in  1  asynchronous active-low reset.
a_en  in  1  port A access request.
a_we  in  1  port A write (1) / read (0); qualified by a_en.
a_addr  in  AW  port A word address.
a_wdata  in  WIDTH  port A write data.
a_rdata  out  WIDTH  port A read data.
a_rvalid  out  1  port A read data valid, one-cycle pulse per read.
b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid: same as port A, for port B.
bank_swap  in  1  one-cycle pulse; toggles bank_sel (PINGPONG=1 only).
bank_sel  out  1  bank currently mapped to port A.
wcoll_cnt  out  16  saturating count of write-write collisions.
addr_err  out  1  sticky flag: an access with addr >= DEPTH occurred.

Behaviour:
- Reset, asynchronous on RSTN low:
  - a_rdata = b_rdata = 0, a_rvalid = b_rvalid = 0.
  - bank_sel = 0, wcoll_cnt = 0, addr_err = 0.
  - Read pipelines flushed; reads in flight when reset asserts are discarded with no rvalid.
  - Memory contents are not reset.
- Writes: en & we samples addr/wdata at the CK edge; the array updates at that edge. A read of the same address on a later cycle returns the new data.
- Reads: en & !we samples addr at edge T.
  - rdata/rvalid appear after edge T+RD_LAT-1, i.e. visible in cycle T+RD_LAT.
  - rvalid is high exactly one cycle per read.
  - rdata holds its last value when rvalid is low.
  - Back-to-back reads are accepted every cycle (fully pipelined).
- Out-of-range address (addr >= DEPTH):
  - write is ignored;
  - read returns 0 with rvalid still asserted;
  - addr_err set to 1 until reset.
- Collisions (PINGPONG=0, both en, a_addr == b_addr, same cycle):
  - A write, B read: B receives a_wdata (write-first forwarding).
  - A read, B write: A receives b_wdata.
  - Both write: a_wdata stored, b write dropped, wcoll_cnt += 1, saturating at 16'hFFFF.
  - Both read: both receive the stored word.
- PINGPONG=1:
  - Port A addresses bank bank_sel; port B addresses bank !bank_sel.
  - Ports never collide; wcoll_cnt stays 0.
- bank_swap:
  - Toggles bank_sel at the edge it is sampled.
  - Accesses in the same cycle as bank_swap use the old mapping.
  - Reads already in the pipeline return data from the bank they were issued to.
  - bank_swap is ignored when PINGPONG=0, and bank_sel stays 0.
- No backpressure: requests are always accepted.
- All outputs are registered.

Test Plan:
1. Reset then write A: addr 5 = 0xA5 (replicated to WIDTH); next cycle read B addr 5 with RD_LAT=1 -> b_rvalid pulses one cycle later with b_rdata = 0xA5.., a_rvalid stays 0.
2. Same cycle, A writes addr 10 = 0x1234 and B reads addr 10 -> b_rdata = 0x1234 forwarded. Next cycle, A reads addr 10 -> 0x1234.
3. Same cycle, A writes addr 3 = 0x11 and B writes addr 3 = 0x22 -> later read gives 0x11, wcoll_cnt = 1. Repeat 65536 times -> wcoll_cnt = 0xFFFF.
4. PINGPONG=1: A writes addr 0 = 0xAA, pulse bank_swap, B reads addr 0 -> 0xAA, bank_sel = 1. A write addr 0 = 0xBB in the same cycle as B's read does not disturb B's result.
5. RD_LAT=2: B reads addrs 0,1,2 on consecutive cycles -> three consecutive rvalid pulses starting 2 cycles after the first request, data in order. Assert RSTN low mid-stream -> rvalid drops to 0 immediately and no pending pulses appear after release.
6. Read addr DEPTH (144) -> rdata = 0, rvalid = 1, addr_err = 1 held. Write addr 200 -> no array change (verify via prior contents).
